// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared constants and types for the calculator datapath:
//               operand width default, op-select codes, FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

  localparam int W_DEFAULT = 8;

  // Op-select codes. s[2]=1 marks an operand-load code, which is never an
  // arithmetic request.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_XLD = 3'b100;
  localparam logic [2:0] OP_YLD = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/calc_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : calc_muldiv
// Description : Iterative unsigned engine. W iterations, one per cycle:
//               shift-add multiply (op_i=0) or restoring divide (op_i=1).
//               Divide result packs {remainder, quotient}.
// Ports       : clk, rst (async, active-low)
//               start_i  - load a_i/b_i and begin (ignored while busy)
//               op_i     - 0 multiply, 1 divide
//               a_i,b_i  - multiplicand/dividend, multiplier/divisor
//               busy_o   - iterations in progress
//               result_o - final value, valid while last_o is high
//               last_o   - high during the cycle whose edge completes
// Revision    : 1.0 - initial release
// ============================================================================
module calc_muldiv
  import calc_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           busy_o,
  output logic [2*W-1:0] result_o,
  output logic           last_o
);

  localparam int CW = $clog2(W + 1);

  // Multiply: acc_q accumulates, sh_q holds the shifted multiplicand and
  // b_q the right-shifting multiplier.
  // Divide:   acc_q = {remainder, dividend/quotient}, b_q the divisor.
  logic [2*W-1:0] acc_q, acc_d, sh_q;
  logic [W-1:0]   b_q;
  logic           div_q, busy_q;
  logic [CW-1:0]  cnt_q;
  logic [W:0]     rem_trial, rem_diff;

  always_comb begin
    acc_d     = acc_q;
    rem_trial = {acc_q[2*W-1:W], acc_q[W-1]};
    rem_diff  = rem_trial - {1'b0, b_q};
    if (div_q) begin
      // Restore-free form: keep the subtraction only when it did not borrow.
      if (!rem_diff[W]) acc_d = {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};
      else              acc_d = {rem_trial[W-1:0], acc_q[W-2:0], 1'b0};
    end else if (b_q[0]) begin
      acc_d = acc_q + sh_q;
    end
  end

  assign busy_o   = busy_q;
  assign last_o   = busy_q && (cnt_q == CW'(W - 1));
  assign result_o = acc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      sh_q   <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i && !busy_q) begin
      acc_q  <= op_i ? {{W{1'b0}}, a_i} : '0;
      sh_q   <= op_i ? '0 : {{W{1'b0}}, a_i};
      b_q    <= b_i;
      div_q  <= op_i;
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      acc_q <= acc_d;
      sh_q  <= sh_q << 1;
      b_q   <= div_q ? b_q : (b_q >> 1);
      cnt_q <= cnt_q + CW'(1);
      if (last_o) busy_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/calc_datapath.sv
`default_nettype none
// ============================================================================
// Module      : calc_datapath
// Description : Calculator datapath: X/Y operand registers, single-cycle
//               add/sub, control FSM, and the iterative mul/div engine.
// Ports       : clk, rst (async, active-low)
//               din            - operand data
//               ldX/clrX       - load (with s=100) / clear X
//               ldY/clrY       - load (with s=101) / clear Y
//               s              - op select
//               done           - operation request
//               result         - last completed result (2W)
//               res_valid      - one-cycle completion pulse
//               busy           - multi-cycle op in progress
//               err            - sticky divide-by-zero flag
// Revision    : 1.0 - initial release
// ============================================================================
module calc_datapath
  import calc_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           ldX,
  input  logic           clrX,
  input  logic           ldY,
  input  logic           clrY,
  input  logic [2:0]     s,
  input  logic           done,
  output logic [2*W-1:0] result,
  output logic           res_valid,
  output logic           busy,
  output logic           err
);

  state_t         state_q;
  logic [W-1:0]   x_q, x_d, y_q, y_d;
  logic [2*W-1:0] result_q;
  logic           res_valid_q, busy_q, err_q;

  logic           w_idle, w_accept, w_md_start, w_md_op;
  logic           w_md_busy, w_md_last;
  logic [2*W-1:0] w_md_result, w_sum, w_diff;

  assign w_idle     = (state_q == ST_IDLE) && !w_md_busy;
  assign w_accept   = w_idle && done && !s[2];
  assign w_md_op    = (s == OP_DIV);
  assign w_md_start = w_accept && ((s == OP_MUL) || ((s == OP_DIV) && (y_q != '0)));

  assign w_sum  = {{(W-1){1'b0}}, ({1'b0, x_q} + {1'b0, y_q})};
  // 2W-bit subtraction of zero-extended operands yields the sign-extended
  // two's-complement difference directly.
  assign w_diff = {{W{1'b0}}, x_q} - {{W{1'b0}}, y_q};

  // Operand registers freeze while an iterative op is running.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (w_idle) begin
      if (clrX)                     x_d = '0;
      else if (ldX && s == OP_XLD)  x_d = din;
      if (clrY)                     y_d = '0;
      else if (ldY && s == OP_YLD)  y_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            err_q <= 1'b0;
            case (s)
              OP_ADD: begin
                result_q    <= w_sum;
                res_valid_q <= 1'b1;
              end
              OP_SUB: begin
                result_q    <= w_diff;
                res_valid_q <= 1'b1;
              end
              OP_MUL: begin
                state_q <= ST_MUL;
                busy_q  <= 1'b1;
              end
              default: begin
                if (y_q == '0) begin
                  result_q    <= '1;
                  err_q       <= 1'b1;
                  res_valid_q <= 1'b1;
                end else begin
                  state_q <= ST_DIV;
                  busy_q  <= 1'b1;
                end
              end
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_md_last) begin
            result_q    <= w_md_result;
            res_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  calc_muldiv #(.W(W)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (w_md_start),
    .op_i     (w_md_op),
    .a_i      (x_q),
    .b_i      (y_q),
    .busy_o   (w_md_busy),
    .result_o (w_md_result),
    .last_o   (w_md_last)
  );

  assign result    = result_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_datapath
// Description : Directed self-checking bench for calc_datapath (W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_datapath;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   din = '0;
  logic           ldX = 1'b0, clrX = 1'b0, ldY = 1'b0, clrY = 1'b0;
  logic [2:0]     s = 3'b000;
  logic           done = 1'b0;
  logic [2*W-1:0] result;
  logic           res_valid, busy, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_datapath #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .din       (din),
    .ldX       (ldX),
    .clrX      (clrX),
    .ldY       (ldY),
    .clrY      (clrY),
    .s         (s),
    .done      (done),
    .result    (result),
    .res_valid (res_valid),
    .busy      (busy),
    .err       (err)
  );

  // Advance one edge; inputs are then changed and outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_x(input logic [W-1:0] v);
    din = v; s = 3'b100; ldX = 1'b1;
    step();
    ldX = 1'b0;
  endtask

  task automatic load_y(input logic [W-1:0] v);
    din = v; s = 3'b101; ldY = 1'b1;
    step();
    ldY = 1'b0;
  endtask

  task automatic request(input logic [2:0] op);
    s = op; done = 1'b1;
    step();
    done = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if ({result, res_valid, busy, err} !== {16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got result=%h rv=%b busy=%b err=%b want 0", result, res_valid, busy, err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    load_x(8'h0C);
    load_y(8'h05);
    request(3'b000);
    checks++;
    if (result !== 16'h0011 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL add got result=%h rv=%b want 0011/1", result, res_valid);
    end
    step();
    checks++;
    if (res_valid !== 1'b0 || result !== 16'h0011) begin
      errors++;
      $display("FAIL add_pulse got rv=%b result=%h want 0/0011", res_valid, result);
    end
  endtask

  task automatic test_sub();
    load_x(8'h03);
    load_y(8'h05);
    request(3'b001);
    checks++;
    if (result !== 16'hFFFE || res_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sub got result=%h rv=%b busy=%b want FFFE/1/0", result, res_valid, busy);
    end
  endtask

  task automatic test_mul();
    int busy_cnt;
    load_x(8'hFF);
    load_y(8'hFF);
    request(3'b010);
    busy_cnt = 0;
    // Edges 1..7 after acceptance: busy, no result yet; junk control inputs.
    for (int i = 1; i < 8; i++) begin
      if (busy === 1'b1) busy_cnt++;
      done = (i == 2); ldX = (i == 3); clrY = (i == 4); clrX = (i == 5);
      s = (i == 3) ? 3'b100 : 3'b000; din = 8'h11;
      step();
      done = 1'b0; ldX = 1'b0; clrY = 1'b0; clrX = 1'b0;
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL mul_early_valid got rv=%b at edge %0d want 0", res_valid, i);
      end
    end
    if (busy === 1'b1) busy_cnt++;
    step();
    checks++;
    if (result !== 16'hFE01 || res_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul got result=%h rv=%b busy=%b want FE01/1/0", result, res_valid, busy);
    end
    checks++;
    if (busy_cnt !== 8) begin
      errors++;
      $display("FAIL mul_busy_cycles got %0d want 8", busy_cnt);
    end
    // Operands must be untouched by the ignored loads/clears.
    step();
    request(3'b000);
    checks++;
    if (result !== 16'h01FE || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL mul_operands_held got result=%h rv=%b want 01FE/1", result, res_valid);
    end
  endtask

  task automatic test_div();
    load_x(8'h64);
    load_y(8'h07);
    request(3'b011);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL div_busy got %b want 1", busy);
    end
    for (int i = 1; i < 8; i++) step();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL div_edge7 got rv=%b busy=%b want 0/1", res_valid, busy);
    end
    step();
    checks++;
    if (result !== 16'h020E || res_valid !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL div got result=%h rv=%b err=%b want 020E/1/0", result, res_valid, err);
    end
  endtask

  task automatic test_div_zero();
    load_y(8'h00);
    request(3'b011);
    checks++;
    if (result !== 16'hFFFF || err !== 1'b1 || res_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL div0 got result=%h err=%b rv=%b busy=%b want FFFF/1/1/0", result, err, res_valid, busy);
    end
    step();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL div0_sticky got err=%b busy=%b rv=%b want 1/0/0", err, busy, res_valid);
    end
    // done with a load code is a no-op: err and result unchanged.
    din = 8'h00;
    request(3'b100);
    checks++;
    if (err !== 1'b1 || res_valid !== 1'b0 || result !== 16'hFFFF) begin
      errors++;
      $display("FAIL noop_load_code got err=%b rv=%b result=%h want 1/0/FFFF", err, res_valid, result);
    end
    request(3'b000);
    checks++;
    if (err !== 1'b0 || result !== 16'h0064) begin
      errors++;
      $display("FAIL err_clear got err=%b result=%h want 0/0064", err, result);
    end
  endtask

  task automatic test_reset_mid();
    int rv_seen;
    load_x(8'h03);
    load_y(8'h05);
    request(3'b010);
    for (int i = 1; i < 4; i++) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({result, res_valid, busy, err} !== {16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL async_reset got result=%h rv=%b busy=%b err=%b want 0", result, res_valid, busy, err);
    end
    step();
    rst_n = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (res_valid !== 1'b0 || busy !== 1'b0) rv_seen++;
    end
    checks++;
    if (rv_seen !== 0) begin
      errors++;
      $display("FAIL post_reset_quiet got %0d active cycles want 0", rv_seen);
    end
    // Operands were cleared by reset: X+Y = 0.
    request(3'b000);
    checks++;
    if (result !== 16'h0000 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_operands got result=%h rv=%b want 0000/1", result, res_valid);
    end
  endtask

  task automatic test_clr_priority();
    load_x(8'h40);
    load_y(8'h09);
    din = 8'h77; s = 3'b100; ldX = 1'b1; clrX = 1'b1;
    step();
    ldX = 1'b0; clrX = 1'b0;
    request(3'b000);
    checks++;
    if (result !== 16'h0009 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL clr_priority got result=%h rv=%b want 0009/1", result, res_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_div_zero();
    test_reset_mid();
    test_clr_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_datapath.md
CALC_DATAPATH -- requirements
Module: calc_datapath

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning operand width; result width is 2*W.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 The block SHALL have port din  input  W  operand data bus.
REQ-005 The block SHALL have port ldX  input  1  load din into X when s=100.
REQ-006 The block SHALL have port clrX  input  1  clear X.
REQ-007 The block SHALL have port ldY  input  1  load din into Y when s=101.
REQ-008 The block SHALL have port clrY  input  1  clear Y.
REQ-009 The block SHALL have port s  input  3  op select: 100 X-load, 101 Y-load, 000 add, 001 sub, 010 mul, 011 div.
REQ-010 The block SHALL have port done  input  1  operation request from the control unit.
REQ-011 The block SHALL have port result  output  2W  last completed result.
REQ-012 The block SHALL have port res_valid  output  1  one-cycle pulse when result updates.
REQ-013 The block SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-014 The block SHALL have port err  output  1  sticky divide-by-zero flag, cleared by the next accepted operation.

Function
REQ-015 X SHALL clear on clrX; else load din on ldX with s=100; clrX wins over ldX in the same cycle; Y likewise with clrY/ldY/s=101.
REQ-016 The FSM SHALL have states IDLE, MUL, DIV; a request is accepted only in IDLE when done=1 and s[2]=0.
REQ-017 Add: result = zero-extended X+Y; result and res_valid=1 in the cycle after acceptance; state stays IDLE.
REQ-018 Sub: result = X-Y as 2W-bit two's complement (sign-extended borrow); same 1-cycle latency as add.
REQ-019 Mul: acceptance latches X and Y into working registers, enters MUL; unsigned shift-add runs W iterations, one per cycle; on the W-th iteration edge result=X*Y, res_valid=1, state returns to IDLE (latency W cycles after acceptance).
REQ-020 Div: unsigned restoring division, W iterations, same timing as mul; result = {remainder[W-1:0], quotient[W-1:0]}.
REQ-021 Div with Y=0 SHALL NOT enter DIV; result=all ones, err=1, res_valid=1 one cycle after acceptance.
REQ-022 busy SHALL be 1 exactly while state is MUL or DIV.
REQ-023 While busy, done, ldX, ldY, clrX and clrY SHALL be ignored; X and Y are unchanged.
REQ-024 res_valid SHALL be high for exactly one cycle per completed operation; result holds until the next completion.
REQ-025 clrX/clrY SHALL NOT affect result, err, or an in-flight operation.
REQ-026 done with s=100 or 101 SHALL be treated as no operation.

Reset
REQ-027 rst=0 SHALL immediately force X=0, Y=0, result=0, res_valid=0, busy=0, err=0, state=IDLE, iteration count=0, including mid-operation; no output pulse follows reset release.

Structure
REQ-028 Shared package calc_pkg SHALL hold the s op-code constants, the FSM state typedef, and the default width.
REQ-029 The iterative engine SHALL be one sub-module calc_muldiv (start, op, a, b -> busy, result, last-iteration strobe); add/sub, operand registers and FSM stay in calc_datapath.

Verification
REQ-030 Load din=0x0C with s=100/ldX, din=0x05 with s=101/ldY, done with s=000 -> next cycle result=0x0011, res_valid single pulse.
REQ-031 X=0x03, Y=0x05, done with s=001 -> result=0xFFFE one cycle later.
REQ-032 X=0xFF, Y=0xFF, done with s=010 -> busy high 8 cycles, result=0xFE01 with res_valid on the 8th edge; done/ldX pulses during busy ignored.
REQ-033 X=0x64, Y=0x07, done with s=011 -> after 8 cycles result=0x020E; then Y=0, done with s=011 -> result=0xFFFF, err=1 after 1 cycle, busy never asserted.
REQ-034 Start mul, assert rst=0 at iteration 4 -> all outputs 0 without waiting for clk; after release, no res_valid until a new request.
REQ-035 clrX and ldX with s=100 in the same cycle -> X=0; then add with Y=0x09 -> result=0x0009.
